// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell, LSB first, behind a start/busy/done handshake.
// Optional borrow-in port enabled by defining SERIAL_SUB_BIN_EN.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic difference,
    output logic borrow
);
    assign difference = a ^ b ^ bin;
    assign borrow     = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           cell_diff;
    logic           cell_borrow;
    logic           start_borrow;

`ifdef SERIAL_SUB_BIN_EN
    assign start_borrow = bin;
`else
    assign start_borrow = 1'b0;
`endif

    full_subtractor u_cell (
        .a          (sa[0]),
        .b          (sb[0]),
        .bin        (br),
        .difference (cell_diff),
        .borrow     (cell_borrow)
    );

    // DONE accepts a new start exactly like IDLE, which gives back-to-back throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            cnt        <= '0;
            br         <= 1'b0;
            sa         <= '0;
            sb         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= start_borrow;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    diff <= {cell_diff, diff[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= cell_borrow;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_out <= cell_borrow;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed cases plus random operands against an arithmetic model.
// Exercises the borrow-in port only when SERIAL_SUB_BIN_EN is defined.

module tb_serial_subtractor_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BIN_EN
    logic             bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int   testsRun = 0;
    int   failCount = 0;
    logic lastBorrow = 1'b0;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
`ifdef SERIAL_SUB_BIN_EN
        .bin        (bin),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one subtraction; optionally pulses a second start at RUN cycle glitchCycle (0 = none).
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opBin, input int glitchCycle, input string tag);
        longint    full;
        longint    mask;
        logic [63:0] expDiff;
        logic      expBorrow;
        int        cycles;
        int        busyCnt;
        logic      doneSeen;
        logic      heldOk;
        mask      = (longint'(1) << WIDTH) - 1;
        full      = longint'(opA) - longint'(opB) - longint'(opBin);
        expBorrow = (full < 0);
        expDiff   = 64'(full & mask);
        a = opA;
        b = opB;
`ifdef SERIAL_SUB_BIN_EN
        bin = opBin;
`endif
        start    = 1'b1;
        cycles   = 0;
        busyCnt  = 0;
        doneSeen = 1'b0;
        heldOk   = 1'b1;
        while (!doneSeen && cycles < 4 * WIDTH) begin
            @(negedge clk);
            cycles++;
            start = (cycles == glitchCycle);
            if (cycles == glitchCycle) begin
                a = WIDTH'(32'h77);
                b = WIDTH'(32'h11);
            end
            if (busy) begin
                busyCnt++;
                if (borrow_out !== lastBorrow) heldOk = 1'b0;
            end
            if (done === 1'b1) doneSeen = 1'b1;
        end
        start = 1'b0;
        checkOutput({tag, " done_seen"}, 64'(doneSeen), 64'd1);
        checkOutput({tag, " latency"}, 64'(cycles), 64'(WIDTH + 1));
        checkOutput({tag, " busy_cycles"}, 64'(busyCnt), 64'(WIDTH));
        checkOutput({tag, " diff"}, 64'(diff), expDiff);
        checkOutput({tag, " borrow_out"}, 64'(borrow_out), 64'(expBorrow));
        checkOutput({tag, " borrow_held_during_run"}, 64'(heldOk), 64'd1);
        @(negedge clk);
        checkOutput({tag, " done_single_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, " diff_stable"}, 64'(diff), expDiff);
        lastBorrow = expBorrow;
    endtask

    initial begin
        int   doneCnt;
        logic pairOk;
        logic diffOk;
        logic noDone;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rbin;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_SUB_BIN_EN
        bin   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset diff", 64'(diff), 64'd0);
        checkOutput("reset borrow_out", 64'(borrow_out), 64'd0);

        applyStimulus(8'h5A, 8'h3C, 1'b0, 0, "5A-3C");
        applyStimulus(8'h00, 8'h01, 1'b0, 0, "00-01");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, "FF-FF");

        // start held high: one result every WIDTH+1 cycles, busy low only in DONE cycles
        a = 8'h03;
        b = 8'h01;
        start   = 1'b1;
        doneCnt = 0;
        pairOk  = 1'b1;
        diffOk  = 1'b1;
        for (int i = 0; i < 3 * (WIDTH + 1); i++) begin
            @(negedge clk);
            if (busy === done) pairOk = 1'b0;
            if (done === 1'b1) begin
                doneCnt++;
                if (diff !== 8'h02) diffOk = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("continuous done_count", 64'(doneCnt), 64'd3);
        checkOutput("continuous busy_vs_done", 64'(pairOk), 64'd1);
        checkOutput("continuous diff", 64'(diffOk), 64'd1);
        @(negedge clk);
        checkOutput("continuous idle_busy", 64'(busy), 64'd0);
        lastBorrow = 1'b0;

        applyStimulus(8'h10, 8'h20, 1'b0, 3, "10-20 ignored_start");

        // reset in the middle of RUN discards the operation
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_reset busy", 64'(busy), 64'd0);
        checkOutput("midrun_reset done", 64'(done), 64'd0);
        checkOutput("midrun_reset diff", 64'(diff), 64'd0);
        checkOutput("midrun_reset borrow_out", 64'(borrow_out), 64'd0);
        noDone = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) noDone = 1'b0;
        end
        checkOutput("midrun_reset no_done_after", 64'(noDone), 64'd1);
        lastBorrow = 1'b0;

`ifdef SERIAL_SUB_BIN_EN
        applyStimulus(8'h10, 8'h00, 1'b1, 0, "bin 10-00-1");
        applyStimulus(8'h00, 8'h00, 1'b1, 0, "bin 00-00-1");
`endif

        for (int n = 0; n < 24; n++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'b0;
`ifdef SERIAL_SUB_BIN_EN
            rbin = 1'($urandom_range(0, 1));
`endif
            applyStimulus(ra, rb, rbin, 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial N-bit subtractor built around a single `full_subtractor` cell, which it instantiates internally. It computes `a - b` over WIDTH clock cycles, one bit per cycle starting at the LSB. A one-cycle-per-bit borrow flip-flop carries the borrow between bits. It is the sequencing controller that lets one subtractor cell serve arbitrary operand widths behind a start/busy/done handshake.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a subtraction; sampled only when `busy`=0.
- `a`  input  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  input  WIDTH  subtrahend; captured on the accepted `start` edge.
- `busy`  output  1  high while bits are being processed (state RUN).
- `done`  output  1  single-cycle pulse; `diff` and `borrow_out` are final.
- `diff`  output  WIDTH  difference register.
- `borrow_out`  output  1  borrow out of the MSB (1 when `a < b` unsigned, with borrow-in = 0).

## Operation
- Internal state:
  - operand shift registers `sa` and `sb` (WIDTH bits each);
  - borrow flip-flop `br`;
  - bit counter `cnt`, $clog2(WIDTH) bits;
  - 2-bit FSM.
- Cell wiring: `full_subtractor` with `A=sa[0]`, `B=sb[0]`, `Bin=br`.
- FSM states and transitions:
  - IDLE: `busy`=0, `done`=0. On `start`=1, capture `sa<=a`, `sb<=b`, `br<=0`, `cnt<=0`, then go to RUN.
  - RUN: `busy`=1. Each edge updates the datapath as follows:
    - `diff<={Difference, diff[WIDTH-1:1]}`;
    - `sa<=sa>>1`, `sb<=sb>>1`;
    - `br<=Borrow`;
    - `cnt<=cnt+1`.
  - RUN exit: on the edge where `cnt==WIDTH-1`, also load `borrow_out<=Borrow` and go to DONE.
  - DONE: `done`=1, `busy`=0, for exactly one cycle.
    - If `start`=1 in DONE, it is accepted exactly as in IDLE and the next state is RUN.
    - Otherwise the next state is IDLE.
- `start` while `busy`=1 is ignored. It is neither queued nor does it disturb the operation.
- `a` and `b` may change freely after the accepting edge.
- `diff` holds partial (shifting) values while `busy`=1. It is valid from the `done` cycle and stays stable until the next accepted `start` plus one edge.
- `borrow_out` changes only on the final RUN edge and holds thereafter.
- Arithmetic: unsigned modulo 2^WIDTH, so `diff = (a - b - bin) mod 2^WIDTH`. Signed interpretation is the consumer's concern; no overflow flag.
- Reset (any state, including mid-RUN):
  - next state IDLE;
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `cnt`=0, `br`=0;
  - the operation in progress is discarded with no `done` pulse;
  - `rst` has priority over `start` on the same edge.

## Timing
- Accepted `start` at edge k: `busy` is high from after edge k through edge k+WIDTH.
- `done` is high in the cycle following edge k+WIDTH, i.e. sampled high at edge k+WIDTH+1.
- Latency from start to `done` is WIDTH+1 cycles.
- Back-to-back throughput: one result every WIDTH+1 cycles, achieved by asserting `start` during the DONE cycle.
- Bit i of `diff` is produced at edge k+1+i. After WIDTH shifts it sits in position i.
- Critical path: a single cell (`Borrow` to `br`); no carry chain.

## Configuration
- `SERIAL_SUB_BIN_EN` defined:
  - adds port `bin` (input, 1 bit) after `b`;
  - `bin` is captured into `br` on the accepted `start` edge, making the block a full WIDTH-bit subtractor with borrow-in, suitable for chaining;
  - `borrow_out` then reflects `a < b + bin`.
- `SERIAL_SUB_BIN_EN` not defined:
  - no `bin` port;
  - `br` is cleared to 0 on start.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start one cycle -> `busy` high 8 cycles, `done` pulse exactly 9 cycles after the start edge, diff=0x1E, borrow_out=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0. `borrow_out` holds 1 until the second op's final edge.
- a=0x10, b=0x20, then `start` pulsed again at RUN cycle 3 with a=0x77, b=0x11 -> second start ignored, result diff=0xF0, borrow_out=1, single `done` pulse.
- `start` held high continuously with a=0x03, b=0x01 -> results diff=0x02 every 9 cycles, one `done` pulse per op, `busy` low only during DONE cycles.
- a=0x80, b=0x01, `rst` asserted for one edge at RUN cycle 4 -> next cycle: IDLE, busy=0, done=0, diff=0x00, borrow_out=0, and no `done` pulse afterwards without a new start.
- With `SERIAL_SUB_BIN_EN`: a=0x10, b=0x00, bin=1 -> diff=0x0F, borrow_out=0. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1.
